// File: rtl/periph_bus_master_if.sv
// periph_bus_master_if: command/response valid-ready channels plus rd/wr peripheral bus
interface periph_bus_master_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic [31:0]      cmd_mask;
  logic [CNT_W-1:0] cmd_limit;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic [CNT_W-1:0] resp_count;
  logic             rd;
  logic             wr;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_limit, resp_ready, rdata,
    output cmd_ready, resp_valid, resp_rdata, resp_err, resp_count, rd, wr, addr, wdata
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_limit, resp_ready, rdata,
    input  cmd_ready, resp_valid, resp_rdata, resp_err, resp_count, rd, wr, addr, wdata
  );
endinterface

// File: rtl/periph_bus_master.sv
// periph_bus_master: single-outstanding WRITE/READ/POLL initiator (clk, async active-low reset, bus = cmd/resp valid-ready + rd/wr/addr/wdata/rdata)
module periph_bus_master #(
  parameter int POLL_GAP = 4,
  parameter int CNT_W    = 16
) (
  input logic                 clk,
  input logic                 reset,
  periph_bus_master_if.master bus
);
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  typedef enum logic [2:0] {IDLE, WRITE, READ, GAP, RESP} state_t;
  state_t           state, state_nxt;
  logic             poll, acc, hit, last;
  logic [31:0]      mask;
  logic [CNT_W-1:0] lim;
  logic [GW-1:0]    gcnt;
  assign acc            = bus.cmd_valid && state == IDLE;
  assign hit            = (bus.rdata & mask) == (bus.wdata & mask);
  assign last           = !poll || hit || bus.resp_count + CNT_W'(1) == lim;
  assign bus.cmd_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.rd         = state == READ;
  assign bus.wr         = state == WRITE && !bus.resp_err;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !acc ? IDLE : bus.cmd_op inside {2'b01, 2'b10} ? READ : WRITE;
      WRITE:   state_nxt = RESP;
      READ:    state_nxt = last ? RESP : POLL_GAP == 0 ? READ : GAP;
      GAP:     state_nxt = gcnt == GW'(POLL_GAP - 1) ? READ : GAP;
      RESP:    state_nxt = bus.resp_ready ? IDLE : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      poll           <= 1'b0;
      mask           <= '0;
      lim            <= '0;
      gcnt           <= '0;
      bus.addr       <= '0;
      bus.wdata      <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.resp_count <= '0;
    end else if (acc) begin
      poll           <= bus.cmd_op == 2'b10;
      mask           <= bus.cmd_mask;
      lim            <= bus.cmd_limit == '0 ? CNT_W'(1) : bus.cmd_limit;
      bus.addr       <= bus.cmd_addr;
      bus.wdata      <= bus.cmd_wdata;
      bus.resp_rdata <= '0;
      bus.resp_err   <= &bus.cmd_op;
      bus.resp_count <= '0;
    end else if (state == READ) begin
      bus.resp_rdata <= bus.rdata;
      bus.resp_count <= bus.resp_count + CNT_W'(1);
      bus.resp_err   <= poll && !hit && last;
      gcnt           <= '0;
    end else if (state == GAP) begin
      gcnt <= gcnt + GW'(1);
    end
endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master: vector table, random commands vs reference model, reset corner cases
module tb_periph_bus_master;
  localparam int G = 4;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, d, m;
    logic [15:0] lim;
    logic [31:0] v0, v1, v2;
    int          rdly;
    logic        err;
    logic [15:0] cnt;
    logic [31:0] rdata;
  } vec_t;
  typedef struct {
    int          nr;
    int          nw;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] rvals [128];
  vec_t tbl [8];
  exp_t e;
  logic r_err;
  logic [15:0] r_cnt;
  logic [31:0] r_rdata;
  logic [1:0] op;
  logic [31:0] a, d, m;
  logic [15:0] lim;
  periph_bus_master_if #(.CNT_W(16)) bus ();
  periph_bus_master #(.POLL_GAP(G), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] dd, input logic [31:0] mm,
                                 input logic [15:0] l);
    exp_t x;
    int n;
    x.nw = o == 2'b00 ? 1 : 0;
    x.nr = 0;
    x.err = o == 2'b11;
    x.rdata = '0;
    if (o == 2'b01) begin
      x.nr = 1;
      x.rdata = rvals[0];
    end
    if (o == 2'b10) begin
      n = l == 0 ? 1 : int'(l);
      x.nr = n;
      x.err = 1'b1;
      for (int k = 0; k < n; k++)
        if ((rvals[k % 128] & mm) == (dd & mm)) begin
          x.nr = k + 1;
          x.err = 1'b0;
          break;
        end
      x.rdata = rvals[(x.nr - 1) % 128];
    end
    x.lat = x.nr == 0 ? 2 : 1 + x.nr + (x.nr - 1) * G;
    return x;
  endfunction
  task automatic run(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] dd,
                     input logic [31:0] mm, input logic [15:0] l, input int rdly,
                     output logic err, output logic [15:0] cnt, output logic [31:0] rdata);
    exp_t x;
    int t, w, bad, nw;
    int rdt [$];
    x = model(o, dd, mm, l);
    t = 0;
    w = 0;
    bad = 0;
    nw = 0;
    @(negedge clk);
    bus.cmd_op = o;
    bus.cmd_addr = aa;
    bus.cmd_wdata = dd;
    bus.cmd_mask = mm;
    bus.cmd_limit = l;
    bus.cmd_valid = 1'b1;
    bus.resp_ready = 1'b0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept", w < 20, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = ~aa;
    bus.cmd_wdata = ~dd;
    bus.cmd_mask = ~mm;
    bus.rdata = rvals[0];
    while (1) begin
      @(negedge clk);
      t++;
      if (bus.rd) begin
        rdt.push_back(t);
        if (bus.addr !== aa) bad++;
      end
      if (bus.wr) begin
        nw++;
        if (bus.addr !== aa || bus.wdata !== dd) bad++;
      end
      if (bus.rd && bus.wr) bad++;
      if (bus.resp_valid || t >= 1000) break;
      @(posedge clk);
      #1;
      bus.rdata = rvals[rdt.size() % 128];
    end
    chk("resp_valid", bus.resp_valid, 1);
    chk("latency", t, x.lat);
    chk("rd_pulses", rdt.size(), x.nr);
    chk("wr_pulses", nw, x.nw);
    for (int k = 0; k < rdt.size() && k < x.nr; k++)
      if (rdt[k] != 1 + k * (G + 1)) bad++;
    err = bus.resp_err;
    cnt = bus.resp_count;
    rdata = bus.resp_rdata;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.cmd_ready || bus.rd || bus.wr || bus.resp_err !== err ||
          bus.resp_count !== cnt || bus.resp_rdata !== rdata) bad++;
    end
    chk("bus_timing_hold", bad, 0);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_resp", {bus.cmd_ready, bus.resp_valid}, 2'b10);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.cmd_mask = '0;
    bus.cmd_limit = '0;
    bus.resp_ready = 1'b0;
    bus.rdata = '0;
    foreach (rvals[k]) rvals[k] = '0;
    tbl[0] = '{2'b00, 32'h4000_0008, 32'h3, 32'h0, 16'd0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 16'd0, 32'h0};
    tbl[1] = '{2'b01, 32'h4000_0014, 32'h0, 32'h0, 16'd0, 32'h1234, 32'h0, 32'h0, 0, 1'b0, 16'd1, 32'h1234};
    tbl[2] = '{2'b10, 32'h4000_0000, 32'h4, 32'h4, 16'd100, 32'h0, 32'h1, 32'h7, 1, 1'b0, 16'd3, 32'h7};
    tbl[3] = '{2'b10, 32'h4000_0004, 32'h4, 32'h4, 16'd3, 32'h0, 32'h0, 32'h0, 0, 1'b1, 16'd3, 32'h0};
    tbl[4] = '{2'b10, 32'h4000_0004, 32'h4, 32'h4, 16'd0, 32'h10, 32'h0, 32'h0, 0, 1'b1, 16'd1, 32'h10};
    tbl[5] = '{2'b11, 32'h4000_000C, 32'h5, 32'h0, 16'd0, 32'h0, 32'h0, 32'h0, 5, 1'b1, 16'd0, 32'h0};
    tbl[6] = '{2'b10, 32'h4000_0010, 32'hF0, 32'hF0, 16'd5, 32'hFF, 32'h0, 32'h0, 0, 1'b0, 16'd1, 32'hFF};
    tbl[7] = '{2'b01, 32'h4000_0018, 32'h0, 32'h0, 16'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 2, 1'b0, 16'd1, 32'hCAFE_F00D};
    repeat (2) @(negedge clk);
    chk("in_reset", {bus.rd, bus.wr, bus.resp_valid}, 3'b000);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_ctl", {bus.cmd_ready, bus.resp_valid, bus.resp_err, bus.rd, bus.wr}, 5'b10000);
    chk("reset_data", {bus.addr, bus.wdata}, 64'h0);
    chk("reset_resp", {bus.resp_rdata, bus.resp_count}, 48'h0);
    foreach (tbl[i]) begin
      foreach (rvals[k]) rvals[k] = '0;
      rvals[0] = tbl[i].v0;
      rvals[1] = tbl[i].v1;
      rvals[2] = tbl[i].v2;
      run(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].lim, tbl[i].rdly, r_err, r_cnt, r_rdata);
      chk($sformatf("vec%0d_err", i), r_err, tbl[i].err);
      chk($sformatf("vec%0d_count", i), r_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_rdata", i), r_rdata, tbl[i].rdata);
    end
    foreach (rvals[k]) rvals[k] = '0;
    @(negedge clk);
    bus.cmd_op = 2'b10;
    bus.cmd_addr = 32'h4000_0020;
    bus.cmd_wdata = 32'h4;
    bus.cmd_mask = 32'h4;
    bus.cmd_limit = 16'd10;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.rdata = '0;
    repeat (3) @(negedge clk);
    chk("gap_quiet", {bus.rd, bus.wr, bus.resp_valid, bus.cmd_ready}, 4'b0000);
    chk("gap_count", bus.resp_count, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_abort", {bus.rd, bus.wr, bus.resp_valid}, 3'b000);
    chk("rst_abort_count", bus.resp_count, 0);
    @(negedge clk);
    reset = 1'b1;
    rvals[0] = 32'h0000_5A5A;
    run(2'b01, 32'h4000_0014, 32'h0, 32'h0, 16'd0, 0, r_err, r_cnt, r_rdata);
    chk("post_rst_rdata", {r_err, r_cnt, r_rdata}, {1'b0, 16'd1, 32'h0000_5A5A});
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      d = $urandom;
      m = $urandom & 32'h0F0F_00F0;
      lim = 16'($urandom_range(0, 6));
      for (int k = 0; k < 8; k++)
        rvals[k] = $urandom_range(0, 2) == 0 ? ((d & m) | ($urandom & ~m)) : $urandom;
      e = model(op, d, m, lim);
      run(op, a, d, m, lim, $urandom_range(0, 3), r_err, r_cnt, r_rdata);
      chk($sformatf("rnd%0d_err", i), r_err, e.err);
      chk($sformatf("rnd%0d_count", i), r_cnt, 16'(e.nr));
      chk($sformatf("rnd%0d_rdata", i), r_rdata, e.rdata);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
